// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Selects by external index (mode=0) or by round-robin arbitration (mode=1).
module rr_stream_mux #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*W-1:0]     in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_chan
);

    logic [SEL_W-1:0] r_ptr;
    logic [W-1:0]     r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_chan;

    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_valid;
    logic             w_fix_valid;
    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic             w_can_load;
    logic [N-1:0]     w_ready;
    logic             w_xfer;
    logic [W-1:0]     w_sel_data;

    // Round-robin search from ptr+1 upward; the wrap is an exact subtract-N.
    always_comb begin
        int unsigned v_idx;
        v_idx      = 0;
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            v_idx = 32'(r_ptr) + k;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            if (!w_rr_valid && in_valid[v_idx]) begin
                w_rr_valid = 1'b1;
                w_rr_idx   = SEL_W'(v_idx);
            end
        end
    end

    // An out-of-range fixed index never grants.
    always_comb begin
        w_fix_valid = 1'b0;
        if (32'(sel) < N) begin
            w_fix_valid = in_valid[sel];
        end
    end

    assign w_grant       = mode ? w_rr_idx   : sel;
    assign w_grant_valid = mode ? w_rr_valid : w_fix_valid;
    assign w_can_load    = !r_out_valid || out_ready;

    always_comb begin
        w_ready    = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_ready[i] = !rst && w_can_load && w_grant_valid;
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    // in_ready is only raised on a channel whose valid is set, so any ready bit is a transfer.
    assign w_xfer = |w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= SEL_W'(N - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_grant;
            r_ptr       <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel and a 3-channel instance
// share clock and reset; expected values are hand-computed constants.
module tb_rr_stream_mux;

    logic        clk;
    logic        rst;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic        mode4;
    logic [1:0]  sel4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic [1:0]  out_chan4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_chan3;

    int checks;
    int failures;

    rr_stream_mux #(.N(4), .W(8)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4), .sel(sel4),
        .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_chan(out_chan4)
    );

    rr_stream_mux #(.N(3), .W(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3),
        .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_chan(out_chan3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs and samples sit 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        in_data4   = '0; in_valid4 = '0; mode4 = 1'b0; sel4 = '0; out_ready4 = 1'b1;
        in_data3   = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;

        // Reset state, with a valid channel present that must not be readied.
        in_valid4 = 4'b0001;
        step();
        #1;
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_out_data",  32'(out_data4),  32'd0);
        check("rst_out_chan",  32'(out_chan4),  32'd0);
        check("rst_in_ready",  32'(in_ready4),  32'd0);
        rst = 1'b0;
        in_valid4 = 4'b0000;
        #1;

        // 1: fixed select of channel 2.
        mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b0100;
        in_data4 = {8'h00, 8'hA5, 8'h00, 8'h00};
        #1;
        check("t1_in_ready", 32'(in_ready4), 32'h4);
        step();
        check("t1_out_valid", 32'(out_valid4), 32'd1);
        check("t1_out_data",  32'(out_data4),  32'hA5);
        check("t1_out_chan",  32'(out_chan4),  32'd2);

        // 2: round-robin, all valid, starting from channel 0 after reset.
        in_valid4 = 4'b0000;
        do_reset();
        mode4 = 1'b1; in_valid4 = 4'b1111;
        in_data4 = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t2_in_ready", 32'(in_ready4), 32'(4'b0001 << (k % 4)));
            step();
            check("t2_out_valid", 32'(out_valid4), 32'd1);
            check("t2_out_data",  32'(out_data4),  32'h10 + 32'(k % 4));
        end

        // 3: sparse valid 1001 with ptr=0 wraps 3 -> 0 -> 3.
        in_valid4 = 4'b1001;
        #1;
        check("t3_in_ready_a", 32'(in_ready4), 32'h8);
        check("t3_onehot_a",   32'($countones(in_ready4)), 32'd1);
        step();
        check("t3_out_data_a", 32'(out_data4), 32'h13);
        check("t3_in_ready_b", 32'(in_ready4), 32'h1);
        step();
        check("t3_out_data_b", 32'(out_data4), 32'h10);
        check("t3_in_ready_c", 32'(in_ready4), 32'h8);
        check("t3_onehot_c",   32'($countones(in_ready4)), 32'd1);
        step();
        check("t3_out_data_c", 32'(out_data4), 32'h13);
        check("t3_out_chan_c", 32'(out_chan4), 32'd3);

        // 4: backpressure holds the beat for 3 cycles.
        out_ready4 = 1'b0; in_valid4 = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_bp_in_ready",  32'(in_ready4),  32'd0);
            check("t4_bp_out_data",  32'(out_data4),  32'h13);
            check("t4_bp_out_valid", 32'(out_valid4), 32'd1);
            step();
        end
        out_ready4 = 1'b1;
        #1;
        check("t4_rel_in_ready", 32'(in_ready4), 32'h1);
        step();
        check("t4_rel_out_valid", 32'(out_valid4), 32'd1);
        check("t4_rel_out_data",  32'(out_data4),  32'h10);
        check("t4_rel_out_chan",  32'(out_chan4),  32'd0);

        // Drain with no new input: valid drops, data holds.
        in_valid4 = 4'b0000;
        step();
        check("drain_out_valid", 32'(out_valid4), 32'd0);
        check("drain_out_data",  32'(out_data4),  32'h10);

        // 5: 3-channel instance, out-of-range select then round-robin.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        in_data3 = {8'h22, 8'h21, 8'h20};
        #1;
        check("t5_sel3_in_ready", 32'(in_ready3), 32'd0);
        step();
        check("t5_sel3_out_valid", 32'(out_valid3), 32'd0);
        mode3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t5_rr_in_ready", 32'(in_ready3), 32'(3'b001 << (k % 3)));
            step();
            check("t5_rr_out_chan", 32'(out_chan3), 32'(k % 3));
            check("t5_rr_out_data", 32'(out_data3), 32'h20 + 32'(k % 3));
        end
        in_valid3 = 3'b000;

        // 6: asynchronous reset mid-cycle while a beat is held (ptr=0, so ch1 loads).
        in_valid4 = 4'b1111;
        step();
        check("t6_pre_out_data", 32'(out_data4), 32'h11);
        out_ready4 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_out_valid", 32'(out_valid4), 32'd0);
        check("t6_async_in_ready",  32'(in_ready4),  32'd0);
        step();
        rst = 1'b0;
        out_ready4 = 1'b1;
        #1;
        check("t6_restart_in_ready", 32'(in_ready4), 32'h1);
        step();
        check("t6_restart_out_data", 32'(out_data4), 32'h10);
        check("t6_restart_out_chan", 32'(out_chan4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshake and one registered output stage.
- Two selection modes: fixed select, where an external index picks the channel, and round-robin, where the block arbitrates fairly among all valid channels.
- Sits between several producer streams and a single consumer, and replaces the purely combinational 4:1 mux wherever buffering or fairness is needed.

Parameters:
- N, 4, number of input channels (N >= 2; need not be a power of two).
- W, 8, data width per channel in bits.
- SEL_W, $clog2(N), width of the channel index. Derived value; not for override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit is high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed-select mode.
- out_data  output  W  registered output data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_chan  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (asynchronous, immediate):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=N-1, so the first round-robin search starts at channel 0.
  - in_ready=0 while rst is high.
- Load condition: can_load = !out_valid | out_ready. The output register accepts a new beat whenever it is empty or being drained in the same cycle, giving full throughput of 1 beat/cycle.
- Grant, computed combinationally each cycle:
  - mode=0: g=sel. The grant is valid only if sel<N and in_valid[sel]=1. sel>=N never grants.
  - mode=1: g is the first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... ptr+N modulo N. The grant is valid if any in_valid bit is set.
- in_ready[i] = can_load & grant_valid & (g==i). All other bits are 0.
  - in_ready may depend combinationally on in_valid, mode and sel.
  - in_ready must never depend on out_data.
- On transfer (in_valid[g] & in_ready[g]) at a clock edge: out_data<=in_data[g], out_chan<=g, out_valid<=1, ptr<=g. ptr updates in both modes.
- If out_valid & out_ready and there is no new transfer: out_valid<=0. out_data and out_chan hold their last values.
- If out_valid & !out_ready: the register holds and all in_ready are 0 (backpressure).
- Latency: a beat accepted at edge k appears on out_data/out_valid right after edge k, i.e. 1 cycle.
- Changing mode or sel affects only the next arbitration. A beat already held is never altered.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... with no repeats inside a window of N.
- Wrap-around: when ptr=N-1 the search starts at channel 0. For non-power-of-two N the modulo is exact, never a bit-truncation.
- Reset asserted mid-stream: a held beat is discarded and the pointer is reinitialised. No partial transfer occurs.

Test Plan:
1. N=4, W=8, mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
2. mode=1, in_valid=4'b1111 held, data ch i = 8'h10+i, out_ready=1 after reset -> out_data sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10; one beat per cycle.
3. mode=1, in_valid=4'b1001, ptr=0 -> grant ch3, then ch0, then ch3 (wrap-around). in_ready never has two bits set.
4. Backpressure: beat held and out_ready=0 for 3 cycles -> in_ready=0, out_data stable. On out_ready=1 a new beat loads the same cycle; out_valid stays 1.
5. N=3 instance, mode=0, sel=3 with in_valid=3'b111 -> in_ready=0 and out_valid stays 0. mode=1 grants in the order 0,1,2,0.
6. Assert rst asynchronously (mid-cycle) while out_valid=1 -> out_valid=0 immediately. After release, round-robin restarts at channel 0.
